// File: rtl/t03_wb_subordinate.sv
// t03_wb_subordinate: Wishbone B4 classic subordinate serving a register bank with programmable wait states.
module t03_wb_subordinate #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          DEPTH       = 16,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        en,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  input  logic [3:0]  SEL_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic        ERR_O
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WS_M1 = WAIT_STATES == 0 ? 4'd0 : 4'(WAIT_STATES - 1);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, sel_q, sel_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0] dat_q, dat_d, rdat_q, rdat_d;
  logic we_q, we_d, hit_q, hit_d, ack_q, ack_d, err_q, err_d, acc;
  logic [29:0] off;
  logic [31:0] bank_q [DEPTH];
  logic [31:0] bank_d [DEPTH];
  always_comb begin
    acc = state_q == S_IDLE && en && CYC_I && STB_I;
    off = ADR_I[31:2] - BASE_ADDR[31:2];
    idx_d = acc ? off[AW-1:0] : idx_q;
    hit_d = acc ? off < 30'(DEPTH) : hit_q;
    dat_d = acc ? DAT_I : dat_q;
    sel_d = acc ? SEL_I : sel_q;
    we_d = acc ? WE_I : we_q;
    state_d = state_q;
    cnt_d = cnt_q;
    bank_d = bank_q;
    if (acc) begin
      state_d = WAIT_STATES == 0 ? S_RESP : S_WAIT;
      cnt_d = WS_M1;
    end else if (state_q == S_WAIT) begin
      state_d = !(CYC_I && STB_I) ? S_IDLE : cnt_q == 4'd0 ? S_RESP : S_WAIT;
      cnt_d = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
    end else if (state_q == S_RESP) begin
      state_d = S_IDLE;
      // the write lands on the edge that closes RESP, before the next IDLE sample
      if (we_q && hit_q)
        for (int n = 0; n < 4; n++)
          if (sel_q[n]) bank_d[idx_q][8*n +: 8] = dat_q[8*n +: 8];
    end
    ack_d = state_d == S_RESP && hit_d;
    err_d = state_d == S_RESP && !hit_d;
    rdat_d = ack_d && !we_d ? bank_q[idx_d] : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      hit_q <= 1'b0;
      dat_q <= '0;
      sel_q <= '0;
      we_q <= 1'b0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      rdat_q <= '0;
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      hit_q <= hit_d;
      dat_q <= dat_d;
      sel_q <= sel_d;
      we_q <= we_d;
      ack_q <= ack_d;
      err_q <= err_d;
      rdat_q <= rdat_d;
      bank_q <= bank_d;
    end
  end
  assign ACK_O = ack_q;
  assign ERR_O = err_q;
  assign DAT_O = rdat_q;
endmodule

// File: doc/t03_wb_subordinate.md
# t03_wb_subordinate

Wishbone B4 classic-cycle subordinate (responder) that serves a bank of DEPTH 32-bit registers behind a base address. It is the far end of the bus the core's wishbone manager drives: it accepts ADR/DAT/SEL/WE/STB/CYC and returns DAT/ACK/ERR. The bank's response latency is programmable by parameter, so the manager's BUSY/ACK handling can be exercised on-chip and in simulation. It also serves as on-chip scratch memory.

## Interface
- BASE_ADDR, 32'h3000_0000: byte address of word 0; must be 4-byte aligned and DEPTH*4-aligned.
- DEPTH, 16: number of 32-bit words, power of two, 2..64.
- WAIT_STATES, 0: extra cycles inserted before ACK/ERR, 0..15.
- clk  in  1  system clock; all logic on rising edge.
- nrst  in  1  reset, synchronous and active-low.
- en  in  1  block enable; when low no new cycle is accepted.
- CYC_I  in  1  bus cycle active.
- STB_I  in  1  strobe, valid transfer request.
- WE_I  in  1  1 = write, 0 = read.
- ADR_I  in  32  byte address.
- DAT_I  in  32  write data.
- SEL_I  in  4  byte lane enables; bit n selects DAT[8n+7:8n].
- DAT_O  out  32  read data, valid only while ACK_O is high, else 0.
- ACK_O  out  1  one-cycle normal termination.
- ERR_O  out  1  one-cycle error termination for an address outside the window.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if en & CYC_I & STB_I, latch ADR_I, DAT_I, SEL_I and WE_I, and set hit = (ADR_I[31:2] - BASE_ADDR[31:2]) < DEPTH.
  - WAIT_STATES = 0 goes directly to RESP.
  - Otherwise load the wait counter with WAIT_STATES-1 and go to WAIT.
- WAIT: decrement the counter; at 0 go to RESP. If CYC_I or STB_I is low in any WAIT cycle, abort to IDLE: no response, no write.
- RESP: for one cycle, assert ACK_O if hit, else ERR_O. Then return to IDLE.
- Word index = ADR_I[2+log2(DEPTH)-1:2] relative to BASE_ADDR. ADR_I[1:0] is ignored; there is no misalignment error.
- Write with hit: at the clock edge that ends the RESP cycle, bank[idx] byte n <= DAT_I byte n for each SEL bit set. Unselected bytes are unchanged. SEL_I = 0 still ACKs but writes nothing.
- Read with hit: DAT_O = bank[idx] during RESP, all 32 bits regardless of SEL.
- A miss (read or write) gives ERR_O, DAT_O = 0, and no state change.
- The latched request is used throughout. Changes on ADR/DAT/SEL/WE after acceptance are ignored.
- en falling mid-transaction does not abort it; the cycle completes normally.
- The bank is writable only through the bus. There is no side port.

## Timing
- Reset (nrst low at a rising edge):
  - state IDLE, counter 0, ACK_O = 0, ERR_O = 0, DAT_O = 0.
  - all bank words 0.
  - Takes priority over any in-flight access; that access gets no response and no write.
- Latency: request sampled in IDLE at edge k; ACK_O/ERR_O is high during cycle k+1+WAIT_STATES, exactly one cycle.
- ACK_O and ERR_O are never high together, and never high outside RESP.
- Back-to-back: the cycle after RESP is always IDLE, so a held STB_I is re-sampled there. Minimum spacing is 2+WAIT_STATES cycles per transfer.
- The manager is required to deassert STB_I in the cycle after ACK/ERR. If it keeps STB_I high, the same transfer is accepted again, which is a legal repeat.
- Read-after-write to the same word on consecutive transfers returns the new data; the write is committed before the next IDLE sample.
- Outputs are registered; there is no combinational path from inputs to ACK_O, ERR_O or DAT_O.

## Test plan
- Reset then read: nrst low 2 cycles; read 0x3000_0008 -> ACK_O in cycle k+1, DAT_O = 0, ERR_O = 0.
- Full write/read, WAIT_STATES = 0: write 0xDEADBEEF, SEL = 4'hF to 0x3000_0004 -> ACK after 1 cycle. Read back -> DAT_O = 0xDEADBEEF.
- Byte lanes: preload 0x1122_3344; write 0xAABB_CCDD with SEL = 4'b0101 -> read gives 0x11BB_33DD.
- Wait states and abort, WAIT_STATES = 3:
  - read -> ACK exactly 4 cycles after acceptance.
  - write with STB dropped in the 2nd WAIT cycle -> no ACK, word unchanged, next access accepted normally.
- Out of window: write 0x3000_0040 with DEPTH = 16 -> ERR_O one cycle, ACK_O = 0, bank unchanged. Read 0x2FFF_FFFC -> ERR_O, DAT_O = 0.
- en and mid-op reset:
  - en = 0 with STB high -> no response indefinitely. Raise en -> accepted next cycle.
  - Reset asserted during WAIT -> IDLE, no ACK, bank cleared.
